// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a request stage publishes the pixel coordinate
// and a display stage one pixel later drives syncs, data enable and colour.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CW       = 10,
    parameter int   RGB_W    = 12
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pix_en,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [CW-1:0]    pix_x,
    output logic [CW-1:0]    pix_y,
    output logic             req_de,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb_out
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          hs_act;
    logic          vs_act;

    // Wrap explicitly at the totals so arithmetic never relies on 2^CW rollover.
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (h_cnt == CW'(H_TOTAL - 1)) begin
            h_next = '0;
            if (v_cnt == CW'(V_TOTAL - 1)) begin
                v_next = '0;
            end else begin
                v_next = v_cnt + CW'(1);
            end
        end else begin
            h_next = h_cnt + CW'(1);
        end
    end

    // Sync windows are decoded from the pre-update counts the display stage samples.
    assign hs_act = (h_cnt >= CW'(HS_START)) && (h_cnt < CW'(HS_END));
    assign vs_act = (v_cnt >= CW'(VS_START)) && (v_cnt < CW'(VS_END));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            req_de      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            de          <= 1'b0;
            rgb_out     <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                h_cnt       <= h_next;
                v_cnt       <= v_next;
                req_de      <= (h_next < CW'(H_ACTIVE)) && (v_next < CW'(V_ACTIVE));
                line_start  <= (h_next == '0);
                frame_start <= (h_next == '0) && (v_next == '0);
                de          <= req_de;
                rgb_out     <= req_de ? rgb_in : '0;
                hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
                vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign pix_x = h_cnt;
    assign pix_y = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small-raster instance exercised in
// detail plus a default 640x480 instance checked across one full line.
module tb_vga_timing_gen;

    localparam int CW    = 10;
    localparam int RGB_W = 12;

    logic             sys_clk;
    logic             sys_rst_n;

    // small raster instance: H 8/1/2/1 (12), V 4/1/1/1 (7)
    logic             pix_en;
    logic [RGB_W-1:0] rgb_in;
    logic [CW-1:0]    pix_x, pix_y;
    logic             req_de, line_start, frame_start, hsync, vsync, de;
    logic [RGB_W-1:0] rgb_out;

    // default 640x480 instance
    logic             pix_en_d;
    logic [RGB_W-1:0] rgb_in_d;
    logic [CW-1:0]    pix_x_d, pix_y_d;
    logic             req_de_d, line_start_d, frame_start_d, hsync_d, vsync_d, de_d;
    logic [RGB_W-1:0] rgb_out_d;

    int n_assert = 0;
    int n_fail   = 0;
    int h = 0, v = 0, ph = 0, pv = 0;
    int hs_low_cnt = 0;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .CW(CW), .RGB_W(RGB_W)
    ) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_en      (pix_en),
        .rgb_in      (rgb_in),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .req_de      (req_de),
        .line_start  (line_start),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb_out     (rgb_out)
    );

    vga_timing_gen u_def (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_en      (pix_en_d),
        .rgb_in      (rgb_in_d),
        .pix_x       (pix_x_d),
        .pix_y       (pix_y_d),
        .req_de      (req_de_d),
        .line_start  (line_start_d),
        .frame_start (frame_start_d),
        .hsync       (hsync_d),
        .vsync       (vsync_d),
        .de          (de_d),
        .rgb_out     (rgb_out_d)
    );

    // colour source: the requested x coordinate itself
    assign rgb_in = RGB_W'(pix_x);

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pix_en pulse after `gap` idle cycles, then check against the raster model.
    task automatic step_chk(input int gap);
        logic exp_de;
        ph = h;
        pv = v;
        repeat (gap) @(negedge sys_clk);
        pix_en = 1'b1;
        @(negedge sys_clk);
        pix_en = 1'b0;
        h = (h + 1) % 12;
        if (h == 0) v = (v + 1) % 7;
        exp_de = (ph < 8) && (pv < 4);
        chk("pix_x",       32'(pix_x),       32'(h));
        chk("pix_y",       32'(pix_y),       32'(v));
        chk("req_de",      32'(req_de),      32'((h < 8) && (v < 4)));
        chk("de",          32'(de),          32'(exp_de));
        chk("rgb_out",     32'(rgb_out),     exp_de ? 32'(ph) : 32'd0);
        chk("hsync",       32'(hsync),       32'(!((ph >= 9) && (ph < 11))));
        chk("vsync",       32'(vsync),       32'(pv != 5));
        chk("line_start",  32'(line_start),  32'(h == 0));
        chk("frame_start", 32'(frame_start), 32'((h == 0) && (v == 0)));
    endtask

    task automatic hold_chk();
        @(negedge sys_clk);
        chk("ls_clear",   32'(line_start),  32'd0);
        chk("fs_clear",   32'(frame_start), 32'd0);
        chk("pix_x_hold", 32'(pix_x),       32'(h));
        chk("pix_y_hold", 32'(pix_y),       32'(v));
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_pix_x"}, 32'(pix_x),       32'd0);
        chk({tag, "_pix_y"}, 32'(pix_y),       32'd0);
        chk({tag, "_req_de"},32'(req_de),      32'd1);
        chk({tag, "_ls"},    32'(line_start),  32'd0);
        chk({tag, "_fs"},    32'(frame_start), 32'd0);
        chk({tag, "_de"},    32'(de),          32'd0);
        chk({tag, "_rgb"},   32'(rgb_out),     32'd0);
        chk({tag, "_hsync"}, 32'(hsync),       32'd1);
        chk({tag, "_vsync"}, 32'(vsync),       32'd1);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        pix_en    = 1'b0;
        pix_en_d  = 1'b0;
        rgb_in_d  = 12'hA5C;

        // reset values, during and after reset
        repeat (3) @(negedge sys_clk);
        reset_vals("rst");
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        reset_vals("post_rst");
        chk("def_hsync_rst", 32'(hsync_d), 32'd1);
        chk("def_req_de_rst", 32'(req_de_d), 32'd1);

        // one full small frame, pix_en every 4th cycle
        for (int k = 1; k <= 84; k++) begin
            step_chk(2);
            if (k == 10 || k == 11) chk("hsync_low_lit", 32'(hsync), 32'd0);
            if (k == 12) begin
                chk("hsync_high_lit", 32'(hsync), 32'd1);
                chk("ls_lit",         32'(line_start), 32'd1);
                chk("pix_y_lit",      32'(pix_y), 32'd1);
            end
            if (k == 84) begin
                chk("fs_lit",    32'(frame_start), 32'd1);
                chk("fs_pix_x",  32'(pix_x), 32'd0);
                chk("fs_pix_y",  32'(pix_y), 32'd0);
            end
            hold_chk();
        end

        // pix_en held high for 29 cycles: lands on pix_x = 5, pix_y = 2
        for (int k = 0; k < 29; k++) step_chk(0);
        chk("pre_rst_x", 32'(pix_x), 32'd5);
        chk("pre_rst_y", 32'(pix_y), 32'd2);
        chk("pre_rst_de", 32'(de), 32'd1);

        // asynchronous mid-line reset, checked before any clock edge
        #2 sys_rst_n = 1'b0;
        #1 reset_vals("async");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        h = 0;
        v = 0;
        step_chk(2);
        chk("after_rst_x",  32'(pix_x), 32'd1);
        chk("after_rst_y",  32'(pix_y), 32'd0);
        chk("after_rst_fs", 32'(frame_start), 32'd0);
        for (int k = 0; k < 13; k++) begin
            step_chk(2);
            hold_chk();
        end

        // default raster: one full line with pix_en held high
        @(negedge sys_clk);
        pix_en_d = 1'b1;
        for (int k = 1; k <= 801; k++) begin
            @(negedge sys_clk);
            if (hsync_d == 1'b0) hs_low_cnt++;
            if (k == 656) chk("def_hs_pre",   32'(hsync_d), 32'd1);
            if (k == 657) chk("def_hs_first", 32'(hsync_d), 32'd0);
            if (k == 752) chk("def_hs_last",  32'(hsync_d), 32'd0);
            if (k == 753) chk("def_hs_post",  32'(hsync_d), 32'd1);
            if (k == 640) begin
                chk("def_de_last", 32'(de_d),      32'd1);
                chk("def_rgb",     32'(rgb_out_d), 32'hA5C);
            end
            if (k == 641) begin
                chk("def_de_off",  32'(de_d),      32'd0);
                chk("def_rgb_off", 32'(rgb_out_d), 32'd0);
            end
            if (k == 799) chk("def_ls_pre", 32'(line_start_d), 32'd0);
            if (k == 800) begin
                chk("def_ls",    32'(line_start_d),  32'd1);
                chk("def_fs",    32'(frame_start_d), 32'd0);
                chk("def_x",     32'(pix_x_d),       32'd0);
                chk("def_y",     32'(pix_y_d),       32'd1);
                chk("def_vsync", 32'(vsync_d),       32'd1);
            end
            if (k == 801) chk("def_ls_post", 32'(line_start_d), 32'd0);
        end
        pix_en_d = 1'b0;
        chk("def_hs_width", 32'(hs_low_cnt), 32'd96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing from the pixel-rate enable produced by the clock divider.
- Runs on the single system clock and advances one pixel per pix_en pulse.
- Has two stages:
  - Request stage: publishes the pixel coordinate so the upstream pixel source can supply colour.
  - Display stage: delays that coordinate by one pixel and drives hsync, vsync, de and rgb_out aligned to each other.
- Sits between the clock divider and the VGA connector pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
CW, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
RGB_W, 12, colour width

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
pix_en  input  1  pixel-rate enable, one sys_clk cycle wide per pixel (may be held high)
rgb_in  input  RGB_W  colour for coordinate (pix_x, pix_y), valid until next pix_en
pix_x  output  CW  request-stage horizontal count
pix_y  output  CW  request-stage vertical count
req_de  output  1  request-stage visible flag
line_start  output  1  one-sys_clk pulse when h_cnt wraps to 0
frame_start  output  1  one-sys_clk pulse when (h_cnt, v_cnt) wraps to (0, 0)
hsync  output  1  display-stage horizontal sync
vsync  output  1  display-stage vertical sync
de  output  1  display-stage data enable
rgb_out  output  RGB_W  display-stage colour, 0 when de = 0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL likewise. Region order is active, front porch, sync, back porch.
- Reset (asynchronous, immediate, also mid-frame):
  - h_cnt = v_cnt = 0.
  - pix_x = pix_y = 0; req_de = 1.
  - line_start = frame_start = 0.
  - de = 0; rgb_out = 0.
  - hsync = vsync = inactive level (~SYNC_POL).
- pix_en = 0: all registers hold, except line_start/frame_start, which clear.
- Request stage, updated on each clock edge with pix_en = 1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0.
  - pix_x = h_cnt and pix_y = v_cnt (registered).
  - req_de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE), computed on the next-count values so it is coincident with pix_x/pix_y.
- Strobes:
  - line_start = 1 for exactly one sys_clk on the edge where h_cnt becomes 0.
  - frame_start = 1 on the edge where both counters become 0. It coincides with that line_start pulse.
  - No strobe is generated out of reset.
- Display stage, on the same pix_en edge, samples the current (pre-update) request state:
  - de <= req_de.
  - rgb_out <= req_de ? rgb_in : 0.
  - hsync <= SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - vsync <= SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (whole lines), else ~SYNC_POL.
- Latency: display outputs lag the request coordinate by exactly one pix_en. The upstream source therefore has a full pixel period to present rgb_in.
- pix_en continuously high is legal: the block runs at the sys_clk pixel rate and strobes then occur every H_TOTAL cycles.
- No other timing changes apply at any boundary; counter arithmetic is modulo the totals, never modulo 2^CW.

Test Plan:
- Small params H 8/1/2/1 (H_TOTAL 12), V 4/1/1/1 (V_TOTAL 7), pix_en every 4th cycle, release reset -> pix_x steps 0..11 then 0; line_start high one sys_clk at the 12th pix_en; pix_y = 1 afterwards.
- Same setup, count pix_en -> hsync low after pix_en #10 and #11 only (h_cnt 9, 10 sampled), high again after #12; de high after pix_en #1..#8 of each active line.
- Run 84 pix_en -> frame_start single-sys_clk pulse with pix_x = pix_y = 0; vsync low for the 12 pix_en periods following sampling of v_cnt = 5.
- rgb_in = pix_x (zero-extended), pix_en held high -> rgb_out equals previous cycle's pix_x while de = 1, and rgb_out = 0 in all blanking pixels.
- Assert sys_rst_n = 0 mid-line at pix_x = 5, pix_y = 2 -> all outputs immediately at reset values without waiting for a clock edge; after release, first pix_en gives pix_x = 1, pix_y = 0, with no frame_start pulse.
- Default params, pix_en every 4th cycle, 420000 pix_en -> frame_start period 1680000 sys_clk; hsync low for 96 pixels starting at sampled h_cnt 656; vsync low for 2 lines starting at sampled v_cnt 490.
